// File: rtl/tt_serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor tile.
//  - state_t          : sequencer states
//  - SUB_W / CNT_W    : default operand width and matching bit-counter width
//  - *_BIT            : pin indices inside the 8-bit tile buses
//  - OE_BASE / OE_OVF : uio output-enable patterns without / with the overflow pad
package tt_serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SUB_W = 6;
    localparam int CNT_W = $clog2(SUB_W);

    localparam int START_BIT  = 6;  // ui_in
    localparam int BORROW_BIT = 6;  // uo_out
    localparam int DONE_BIT   = 7;  // uo_out
    localparam int BUSY_BIT   = 7;  // uio_out
    localparam int OVF_BIT    = 6;  // uio_out

    localparam logic [7:0] OE_BASE = 8'h80;
    localparam logic [7:0] OE_OVF  = 8'hC0;

endpackage

// File: rtl/tt_serial_sub_full_sub_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
// Built as two cascaded half-subtractors whose borrows are ORed.
// Ports: a, b, bin (in); d, bout (out).
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1_s;
    logic b1_s;
    logic b2_s;

    // First stage subtracts b from a, second subtracts the incoming borrow.
    assign d1_s = a ^ b;
    assign b1_s = ~a & b;
    assign d    = d1_s ^ bin;
    assign b2_s = ~d1_s & bin;
    assign bout = b1_s | b2_s;

endmodule

// File: rtl/tt_um_serial_sub.sv
// TinyTapeout tile: bit-serial WIDTH-bit subtractor (A - B), LSB first,
// one bit per enabled clock through a single full_sub_cell.
// Ports:
//  clk, rst_n (async active-low), ena (low = freeze all state)
//  ui_in  : [5:0] operand A, [6] start (rising edge acts), [7] unused
//  uio_in : [5:0] operand B, [7:6] unused
//  uo_out : [5:0] difference, [6] borrow_out, [7] done
//  uio_out: [7] busy, [6] ovf (only with SERIAL_SUB_OVF_EN), others 0
//  uio_oe : 8'h80, or 8'hC0 when SERIAL_SUB_OVF_EN is defined
// Optional feature macro: SERIAL_SUB_OVF_EN adds a two's-complement overflow flag.
module tt_um_serial_sub
    import tt_serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               bin_q, bin_d;
    logic               borrow_q, borrow_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               rise_s;
    logic               d_s;
    logic               bout_s;
    logic               capture_s;
    logic               finish_s;
    logic               ovf_s;
    logic               unused_s;

    // Pins that carry no function at this WIDTH are collected here.
    assign unused_s = &{1'b0, ui_in, uio_in};

    assign rise_s = ui_in[START_BIT] & ~start_q;

    full_sub_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bin_q),
        .d    (d_s),
        .bout (bout_s)
    );

    // Next-state logic: start edge detect, capture, serial step and completion.
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        result_d  = result_q;
        bin_d     = bin_q;
        borrow_d  = borrow_q;
        done_d    = done_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        finish_s  = 1'b0;
        if (ena) begin
            start_d = ui_in[START_BIT];
            case (state_q)
                IDLE, DONE: begin
                    if (rise_s) begin
                        capture_s = 1'b1;
                        state_d   = SHIFT;
                        a_d       = ui_in[WIDTH-1:0];
                        b_d       = uio_in[WIDTH-1:0];
                        bin_d     = 1'b0;
                        cnt_d     = {CW{1'b0}};
                        done_d    = 1'b0;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                SHIFT: begin
                    // New difference bit enters at the MSB so that after WIDTH
                    // steps the first (LSB) bit has reached position 0.
                    work_d = {d_s, work_q[WIDTH-1:1]};
                    a_d    = {1'b0, a_q[WIDTH-1:1]};
                    b_d    = {1'b0, b_q[WIDTH-1:1]};
                    bin_d  = bout_s;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        finish_s = 1'b1;
                        state_d  = DONE;
                        result_d = {d_s, work_q[WIDTH-1:1]};
                        borrow_d = bout_s;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        state_d = SHIFT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            start_d = start_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            work_q   <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            result_q <= result_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow flag. On the final step a_q[0]/b_q[0] hold the operand sign
    // bits and d_s is the result sign bit, so no extra storage is needed.
    always_comb begin
        ovf_d = ovf_q;
        if (capture_s) begin
            ovf_d = 1'b0;
        end else if (finish_s) begin
            ovf_d = (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_s);
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_s  = ovf_q;
    assign uio_oe = OE_OVF;
`else
    assign ovf_s  = 1'b0;
    assign uio_oe = OE_BASE;
`endif

    // Pin mapping; every driven bit comes straight from a register.
    always_comb begin
        uo_out              = 8'h00;
        uo_out[WIDTH-1:0]   = result_q;
        uo_out[BORROW_BIT]  = borrow_q;
        uo_out[DONE_BIT]    = done_q;
        uio_out             = 8'h00;
        uio_out[BUSY_BIT]   = busy_q;
        uio_out[OVF_BIT]    = ovf_s;
    end

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Self-checking bench for tt_um_serial_sub: directed scenarios followed by a
// random operand sweep, all checked against an integer-arithmetic model.
module tb_tt_um_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [5:0] last_diff;   // difference the bench expects on uo_out[5:0] now
    int         lat;
    int         busy_n;

`ifdef SERIAL_SUB_OVF_EN
    localparam logic [7:0] EXP_OE = 8'hC0;
`else
    localparam logic [7:0] EXP_OE = 8'h80;
`endif

    always #5 clk = ~clk;

    tt_um_serial_sub dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_diff(input int a, input int b);
        int d;
        d = a - b;
        if (d < 0) d = d + 64;
        return d;
    endfunction

    function automatic int m_borrow(input int a, input int b);
        return (a < b) ? 1 : 0;
    endfunction

    function automatic int m_ovf(input int a, input int b);
        int sa;
        int sb;
        int r;
        sa = (a >= 32) ? a - 64 : a;
        sb = (b >= 32) ? b - 64 : b;
        r  = sa - sb;
        return (r < -32 || r > 31) ? 1 : 0;
    endfunction

    // One operation: pulse start with a/b, optionally freeze ena for 3 cycles
    // from negedge stall_at, optionally re-pulse start with junk at poke_at.
    task automatic do_op(input int a, input int b, input int stall_at, input int poke_at);
        logic [7:0] tmp;
        int stall_len;
        stall_len = (stall_at > 0) ? 3 : 0;
        @(negedge clk);
        tmp = 8'(a);
        ui_in = {2'b01, tmp[5:0]};
        tmp = 8'(b);
        uio_in = {2'b00, tmp[5:0]};
        lat = 0;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ui_in[6] = 1'b0;
            lat++;
            if (uo_out[7] === 1'b1) break;
            busy_n += (uio_out[7] === 1'b1) ? 1 : 0;
            if (uio_out[7] === 1'b1) chk("hold_prev", 32'(uo_out[5:0]), 32'(last_diff));
            if (lat == stall_at) ena = 1'b0;
            if (stall_at > 0 && lat == stall_at + 3) ena = 1'b1;
            if (lat == poke_at) begin
                ui_in  = {2'b01, 6'($urandom_range(0, 63))};
                uio_in = {2'b00, 6'($urandom_range(0, 63))};
            end
        end
        chk("latency", lat, 7 + stall_len);
        chk("busy_cycles", busy_n, 6 + stall_len);
        chk("busy_at_done", 32'(uio_out[7]), 0);
        chk("diff", 32'(uo_out[5:0]), m_diff(a, b));
        chk("borrow", 32'(uo_out[6]), m_borrow(a, b));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(uio_out[6]), m_ovf(a, b));
`else
        chk("ovf_off", 32'(uio_out[6]), 0);
`endif
        last_diff = 6'(m_diff(a, b));
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        ui_in     = 8'h00;
        uio_in    = 8'h00;
        last_diff = 6'd0;

        // Reset state
        #12;
        chk("rst_uo_out", 32'(uo_out), 0);
        chk("rst_uio_out", 32'(uio_out), 0);
        chk("rst_uio_oe", 32'(uio_oe), 32'(EXP_OE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_uo_out", 32'(uo_out), 0);

        // Directed arithmetic cases
        do_op(23, 5, 0, 0);
        do_op(5, 23, 0, 0);
        do_op(63, 63, 0, 0);

        // DONE holds its outputs with no new start
        repeat (3) @(negedge clk);
        chk("done_hold_uo", 32'(uo_out), 32'h80);
        chk("done_hold_busy", 32'(uio_out[7]), 0);

        // Start held high for 20 cycles -> exactly one operation
        @(negedge clk);
        ui_in  = {2'b01, 6'd40};
        uio_in = {2'b00, 6'd7};
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_n += (uio_out[7] === 1'b1) ? 1 : 0;
        end
        ui_in[6] = 1'b0;
        chk("held_busy_cycles", busy_n, 6);
        chk("held_done", 32'(uo_out[7]), 1);
        chk("held_diff", 32'(uo_out[5:0]), m_diff(40, 7));
        last_diff = 6'(m_diff(40, 7));

        // Start re-pulsed mid-SHIFT with new operands -> ignored
        do_op(50, 20, 0, 3);
        repeat (5) @(negedge clk);
        chk("no_restart_busy", 32'(uio_out[7]), 0);
        chk("no_restart_diff", 32'(uo_out[5:0]), m_diff(50, 20));

        // ena low for 3 cycles mid-SHIFT -> done 3 cycles late
        do_op(40, 9, 2, 0);

        // Reset asserted during SHIFT
        @(negedge clk);
        ui_in  = {2'b01, 6'd12};
        uio_in = {2'b00, 6'd30};
        @(negedge clk);
        ui_in[6] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_uo_out", 32'(uo_out), 0);
        chk("midrst_uio_out", 32'(uio_out), 0);
        chk("midrst_uio_oe", 32'(uio_oe), 32'(EXP_OE));
        @(negedge clk);
        rst_n = 1'b1;
        last_diff = 6'd0;
        repeat (3) @(negedge clk);
        chk("postrst_idle", 32'(uo_out), 0);
        chk("postrst_busy", 32'(uio_out[7]), 0);

        // Overflow-oriented cases (ovf checked or confirmed absent inside do_op)
        do_op(32, 1, 0, 0);
        do_op(10, 3, 0, 0);
        do_op(31, 63, 0, 0);

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            do_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
